seq_8bit_divider: RTL and testbench

Iterative unsigned restoring divider: accepts a dividend/divisor pair on a start strobe and produces quotient and remainder after one trial subtraction per bit. Serves as the subtract-based inverse of the ripple-carry adder in the ALU datapath. Intended for the DIV/MOD instructions, where the control unit stalls on `busy` and samples results on `done`.

---
 rtl/seq_8bit_divider_pkg.sv | 18 +
 rtl/seq_8bit_divider_subtractor.sv | 39 +++
 rtl/seq_8bit_divider.sv | 163 ++++++++++++++++
 tb/tb_seq_8bit_divider.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seq_8bit_divider_pkg.sv
// Shared ALU package: divider FSM states and width constants.
package seq_8bit_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   localparam int DIV_WIDTH_DEFAULT = 8;
   localparam int DIV_CNT_WIDTH_DEFAULT = $clog2(DIV_WIDTH_DEFAULT + 1);

   // Counter must hold WIDTH itself, hence WIDTH+1 codes.
   function automatic int div_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_8bit_divider_subtractor.sv
// Combinational ripple subtractor (a - b = a + ~b + 1) built from a full_adder chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_subtractor #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] diff,
   output logic         borrow
);
   logic [W:0]   carry;
   logic [W-1:0] b_inv;

   assign carry[0] = 1'b1;
   assign b_inv    = ~b;

   for (genvar i = 0; i < W; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b_inv[i]),
         .cin  (carry[i]),
         .sum  (diff[i]),
         .cout (carry[i+1])
      );
   end

   // No carry out of the top bit means a < b.
   assign borrow = ~carry[W];
endmodule

// File: rtl/seq_8bit_divider.sv
// Iterative unsigned restoring divider, one trial subtraction per clock.
// Optional feature: SEQ_DIV_ZERO_DETECT_EN short-circuits a zero divisor straight to DONE.
module seq_8bit_divider
   import seq_8bit_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   localparam int CW = div_cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   div_state_e       state;
   div_state_e       state_next;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] q_sr;
   logic [WIDTH-1:0] divisor_lat;
   logic [CW-1:0]    cnt;

   logic             accept;
   logic             iterate;
   logic             finish;
   logic             zero_div;
   logic             zero_skip;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;
   logic             trial_borrow;
   logic [WIDTH:0]   rem_new;
   logic [WIDTH-1:0] q_new;

`ifdef SEQ_DIV_ZERO_DETECT_EN
   assign zero_div = (divisor == {WIDTH{1'b0}});
`else
   assign zero_div = 1'b0;
`endif

   // Shift {R,Q} left one place, then try subtracting the divisor.
   assign rem_shift = {rem[WIDTH-1:0], q_sr[WIDTH-1]};

   ripple_subtractor #(.W(WIDTH + 1)) u_sub (
      .a      (rem_shift),
      .b      ({1'b0, divisor_lat}),
      .diff   (trial),
      .borrow (trial_borrow)
   );

   assign rem_new = trial_borrow ? rem_shift : trial;
   assign q_new   = {q_sr[WIDTH-2:0], ~trial_borrow};

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and per-cycle control strobes.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      iterate    = 1'b0;
      finish     = 1'b0;
      zero_skip  = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               accept = 1'b1;
               if (zero_div) begin
                  zero_skip  = 1'b1;
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_RUN;
               end
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            iterate = 1'b1;
            if (cnt == LAST_ITER) begin
               finish     = 1'b1;
               state_next = ST_DONE;
            end else begin
               state_next = ST_RUN;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Datapath, iteration counter and registered result/status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem         <= {(WIDTH+1){1'b0}};
         q_sr        <= {WIDTH{1'b0}};
         divisor_lat <= {WIDTH{1'b0}};
         cnt         <= {CW{1'b0}};
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= {WIDTH{1'b0}};
         remainder   <= {WIDTH{1'b0}};
      end else if (accept) begin
         rem         <= {(WIDTH+1){1'b0}};
         q_sr        <= dividend;
         divisor_lat <= divisor;
         cnt         <= {CW{1'b0}};
         if (zero_skip) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {WIDTH{1'b1}};
            remainder <= dividend;
         end else begin
            busy      <= 1'b1;
            done      <= 1'b0;
         end
      end else if (iterate) begin
         rem  <= rem_new;
         q_sr <= q_new;
         cnt  <= cnt + CNT_ONE;
         if (finish) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_new;
            remainder <= rem_new[WIDTH-1:0];
         end
      end else begin
         done <= 1'b0;
      end
   end

`ifdef SEQ_DIV_ZERO_DETECT_EN
   // Zero-divisor flag, refreshed whenever a new result is published.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_by_zero <= 1'b0;
      end else if (zero_skip) begin
         div_by_zero <= 1'b1;
      end else if (finish) begin
         div_by_zero <= 1'b0;
      end else begin
         div_by_zero <= div_by_zero;
      end
   end
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_8bit_divider.sv
// Directed self-checking bench for seq_8bit_divider (WIDTH=8).
module tb_seq_8bit_divider;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = 8'd0;
   logic [7:0] divisor = 8'd0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_8bit_divider #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, want);
      end
   endtask

   // Drive a start for one cycle; returns at the negedge after E0.
   task automatic pulse_start(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts negedges until done (bounded), and how many of them saw busy.
   task automatic wait_done(output int cyc, output int bcyc);
      cyc  = 0;
      bcyc = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (busy === 1'b1) bcyc++;
      end
      if (done !== 1'b1) check("done_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] q_e, input logic [7:0] r_e,
                          input int lat_e, input logic dbz_e);
      int cyc;
      int bcyc;
      pulse_start(a, b);
      wait_done(cyc, bcyc);
      check({tag, "_lat"},  cyc, lat_e);
      check({tag, "_busyn"}, bcyc, lat_e);
      check({tag, "_busy0"}, {31'd0, busy}, 32'd0);
      check({tag, "_q"},    {24'd0, quotient}, {24'd0, q_e});
      check({tag, "_r"},    {24'd0, remainder}, {24'd0, r_e});
      check({tag, "_dbz"},  {31'd0, div_by_zero}, {31'd0, dbz_e});
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_hold"},  {24'd0, quotient}, {24'd0, q_e});
   endtask

   initial begin
      int cyc;
      int bcyc;
      int extra_done;

      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_q",    {24'd0, quotient}, 32'd0);
      check("rst_r",    {24'd0, remainder}, 32'd0);
      check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_div("basic_100_7", 8'd100, 8'd7, 8'd14, 8'd2, 8, 1'b0);
`ifdef SEQ_DIV_ZERO_DETECT_EN
      run_div("zero_200_0", 8'd200, 8'd0, 8'd255, 8'd200, 0, 1'b1);
`else
      run_div("zero_200_0", 8'd200, 8'd0, 8'd255, 8'd200, 8, 1'b0);
`endif
      run_div("max_255_1",   8'd255, 8'd1,   8'd255, 8'd0,  8, 1'b0);
      run_div("small_5_9",   8'd5,   8'd9,   8'd0,   8'd5,  8, 1'b0);
      run_div("zero_num_0_3", 8'd0,  8'd3,   8'd0,   8'd0,  8, 1'b0);
      run_div("eq_255_255",  8'd255, 8'd255, 8'd1,   8'd0,  8, 1'b0);
      run_div("mid_254_15",  8'd254, 8'd15,  8'd16,  8'd14, 8, 1'b0);

      // Start during RUN must be dropped.
      pulse_start(8'd77, 8'd5);
      @(negedge clk);
      start = 1'b1; dividend = 8'd10; divisor = 8'd2;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, bcyc);
      check("ign_lat", cyc + 2, 8);
      check("ign_q", {24'd0, quotient}, 32'd15);
      check("ign_r", {24'd0, remainder}, 32'd2);
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1) extra_done++;
      end
      check("ign_no_second", extra_done, 0);

      // Back-to-back: start held in the DONE cycle.
      pulse_start(8'd9, 8'd4);
      wait_done(cyc, bcyc);
      check("b2b1_q", {24'd0, quotient}, 32'd2);
      check("b2b1_r", {24'd0, remainder}, 32'd1);
      start = 1'b1; dividend = 8'd50; divisor = 8'd6;
      @(negedge clk);
      start = 1'b0;
      check("b2b_pulse", {31'd0, done}, 32'd0);
      check("b2b_busy",  {31'd0, busy}, 32'd1);
      wait_done(cyc, bcyc);
      check("b2b2_lat", cyc + 1, 9);
      check("b2b2_q", {24'd0, quotient}, 32'd8);
      check("b2b2_r", {24'd0, remainder}, 32'd2);
      @(negedge clk);

      // Reset during the 4th iteration of 100/7.
      pulse_start(8'd100, 8'd7);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      check("mid_rst_done", {31'd0, done}, 32'd0);
      check("mid_rst_q",    {24'd0, quotient}, 32'd0);
      check("mid_rst_r",    {24'd0, remainder}, 32'd0);
      check("mid_rst_dbz",  {31'd0, div_by_zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) extra_done++;
      end
      check("mid_rst_quiet", extra_done, 0);
      run_div("after_rst_20_3", 8'd20, 8'd3, 8'd6, 8'd2, 8, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
